// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the SPU instruction-fetch controller:
// filler instructions, FSM encoding and the terminator-opcode check.
package fetch_controller_pkg;

    localparam logic [0:31] NOP_EVEN = 32'h0020_0000;
    localparam logic [0:31] NOP_ODD  = 32'h4020_0000;

    localparam logic [2:0] S_REQ   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        REQ   = S_REQ,
        WAIT  = S_WAIT,
        HOLD  = S_HOLD,
        FLUSH = S_FLUSH,
        DONE  = S_DONE
    } fetch_state_t;

    // A program ends at the first word whose 11-bit opcode field is all zero.
    function automatic logic is_terminator(input logic [0:31] inst);
        return inst[0:10] == 11'b0;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory read port: single outstanding doubleword read with
// req/gnt request phase and rvalid response phase.
interface fetch_controller_if;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [0:63] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_pair_former.sv
// Builds the even/odd decode pair from one fetched doubleword and reports how
// far the PC advances and whether the program terminator was hit.
module fetch_pair_former
    import fetch_controller_pkg::*;
#(
    parameter logic [0:31] NOP_EVEN = fetch_controller_pkg::NOP_EVEN,
    parameter logic [0:31] NOP_ODD  = fetch_controller_pkg::NOP_ODD
) (
    input  logic [0:31] w0,
    input  logic [0:31] w1,
    input  logic        odd_target,
    output logic [0:31] first_inst,
    output logic [0:31] second_inst,
    output logic [0:31] pc_inc,
    output logic        term_now,
    output logic        term_after
);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        first_inst  = w0;
        second_inst = w1;
        pc_inc      = 32'd8;
        term_now    = 1'b0;
        term_after  = 1'b0;
        if (odd_target) begin
            // w0 is the word before the branch target and must not issue.
            first_inst = NOP_EVEN;
            pc_inc     = 32'd4;
            if (is_terminator(w1)) begin
                second_inst = NOP_ODD;
                pc_inc      = 32'd0;
                term_now    = 1'b1;
            end
        end else if (is_terminator(w0)) begin
            first_inst  = NOP_EVEN;
            second_inst = NOP_ODD;
            pc_inc      = 32'd0;
            term_now    = 1'b1;
        end else if (is_terminator(w1)) begin
            second_inst = NOP_ODD;
            pc_inc      = 32'd4;
            term_after  = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues doubleword reads and hands
// even/odd instruction pairs to decode with stall, redirect and flush handling.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 2048,
    parameter logic [0:31] NOP_EVEN   = fetch_controller_pkg::NOP_EVEN,
    parameter logic [0:31] NOP_ODD    = fetch_controller_pkg::NOP_ODD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [0:31]        pc_input,
    fetch_controller_if.master imem,
    output logic               pair_valid,
    output logic [0:31]        first_inst,
    output logic [0:31]        second_inst,
    output logic [0:31]        pc_output,
    output logic               done
);

    localparam logic [0:31] ADDR_MASK = 32'(IMEM_BYTES - 1) & ~32'h7;

    fetch_state_t state_q, state_d;
    logic [0:31]  pc_q, pc_d;
    logic [0:31]  first_q, first_d, second_q, second_d;
    logic         pair_valid_q, pair_valid_d;
    logic         done_q, done_d;
    logic         req_q, req_d;
    logic         discard_q, discard_d;
    logic         term_pending_q, term_pending_d;

    logic [0:31]  f_first, f_second, f_pc_inc;
    logic         f_term_now, f_term_after;
    logic         outstanding;

    fetch_pair_former #(.NOP_EVEN(NOP_EVEN), .NOP_ODD(NOP_ODD)) u_former (
        .w0          (imem.imem_rdata[0:31]),
        .w1          (imem.imem_rdata[32:63]),
        .odd_target  (pc_q[29]),
        .first_inst  (f_first),
        .second_inst (f_second),
        .pc_inc      (f_pc_inc),
        .term_now    (f_term_now),
        .term_after  (f_term_after)
    );

    // A response is still owed if we wait without data, or are granted right now.
    assign outstanding = (state_q == WAIT && !imem.imem_rvalid) ||
                         (state_q == REQ && req_q && imem.imem_gnt);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        first_d        = first_q;
        second_d       = second_q;
        pair_valid_d   = pair_valid_q;
        done_d         = done_q;
        discard_d      = discard_q;
        term_pending_d = term_pending_q;

        if (branch_taken && state_q != FLUSH) begin
            pair_valid_d   = 1'b0;
            first_d        = NOP_EVEN;
            second_d       = NOP_ODD;
            done_d         = 1'b0;
            term_pending_d = 1'b0;
            if (outstanding) begin
                state_d   = FLUSH;
                discard_d = 1'b1;
            end else begin
                state_d = REQ;
            end
        end else begin
            unique case (state_q)
                REQ: if (req_q && imem.imem_gnt) state_d = WAIT;
                WAIT: if (imem.imem_rvalid) begin
                    first_d      = f_first;
                    second_d     = f_second;
                    pc_d         = pc_q + f_pc_inc;
                    pair_valid_d = 1'b1;
                    if (f_term_now) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = HOLD;
                        term_pending_d = f_term_after;
                    end
                end
                HOLD: if (!stall) begin
                    if (term_pending_q) begin
                        state_d        = DONE;
                        done_d         = 1'b1;
                        first_d        = NOP_EVEN;
                        second_d       = NOP_ODD;
                        term_pending_d = 1'b0;
                    end else begin
                        state_d      = REQ;
                        pair_valid_d = 1'b0;
                    end
                end
                FLUSH: if (imem.imem_rvalid && discard_q) begin
                    discard_d = 1'b0;
                    state_d   = REQ;
                end
                DONE: ;
                default: state_d = REQ;
            endcase
        end

        // A redirect in FLUSH only retargets the PC; the stale response is still dropped.
        if (branch_taken) pc_d = pc_input & ~32'h3;
        req_d = (state_d == REQ);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= REQ;
            pc_q           <= '0;
            first_q        <= NOP_EVEN;
            second_q       <= NOP_ODD;
            pair_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            req_q          <= 1'b0;
            discard_q      <= 1'b0;
            term_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            first_q        <= first_d;
            second_q       <= second_d;
            pair_valid_q   <= pair_valid_d;
            done_q         <= done_d;
            req_q          <= req_d;
            discard_q      <= discard_d;
            term_pending_q <= term_pending_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q & ADDR_MASK;
    assign pair_valid     = pair_valid_q;
    assign first_inst     = first_q;
    assign second_inst    = second_q;
    assign pc_output      = pc_q;
    assign done           = done_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a cycle table for straight-line fetch
// plus hand sequences for terminator, stall, odd branch, flush and reset cases.
module tb_fetch_controller;

    localparam logic [0:31] T_NOP_EVEN = 32'h0020_0000;
    localparam logic [0:31] T_NOP_ODD  = 32'h4020_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [0:31] pc_input = '0;
    logic        pair_valid, done;
    logic [0:31] first_inst, second_inst, pc_output;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_controller_if imem_if ();

    fetch_controller dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .pc_input     (pc_input),
        .imem         (imem_if.master),
        .pair_valid   (pair_valid),
        .first_inst   (first_inst),
        .second_inst  (second_inst),
        .pc_output    (pc_output),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Memory model: grant every request, answer after lat cycles.
    logic [0:31] mem [0:511];
    int          lat = 1;
    int          pend_cnt = 0;
    logic [0:31] pend_addr = '0;

    function automatic logic [0:63] rd_pair(input logic [0:31] a);
        int unsigned idx;
        idx = ((32'(a) % 2048) / 4) & 32'h1FE;
        return {mem[idx], mem[idx + 1]};
    endfunction

    function automatic logic [0:31] word_at(input int i);
        return 32'h8000_0000 | 32'(i);
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < 512; i++) mem[i] = (i < n) ? word_at(i) : 32'h0;
    endtask

    assign imem_if.imem_gnt = imem_if.imem_req;

    always @(posedge clock) begin
        imem_if.imem_rvalid <= 1'b0;
        if (imem_if.imem_req && imem_if.imem_gnt) begin
            if (lat <= 1) begin
                imem_if.imem_rvalid <= 1'b1;
                imem_if.imem_rdata  <= rd_pair(imem_if.imem_addr);
            end else begin
                pend_cnt  <= lat - 1;
                pend_addr <= imem_if.imem_addr;
            end
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) begin
                imem_if.imem_rvalid <= 1'b1;
                imem_if.imem_rdata  <= rd_pair(pend_addr);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic req, input logic [0:31] addr,
                              input logic pv, input logic [0:31] f, input logic [0:31] s,
                              input logic [0:31] pc, input logic dn);
        check({name, ".req"},    64'(imem_if.imem_req),  64'(req));
        check({name, ".addr"},   64'(imem_if.imem_addr), 64'(addr));
        check({name, ".pv"},     64'(pair_valid),        64'(pv));
        check({name, ".first"},  64'(first_inst),        64'(f));
        check({name, ".second"}, 64'(second_inst),       64'(s));
        check({name, ".pc"},     64'(pc_output),         64'(pc));
        check({name, ".done"},   64'(done),              64'(dn));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        pc_input = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_pair(input string name);
        int n = 0;
        @(negedge clock);
        while (pair_valid !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check({name, " pair_valid reached"}, 64'(pair_valid), 64'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        @(negedge clock);
        while (imem_if.imem_req !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check({name, " req reached"}, 64'(imem_if.imem_req), 64'd1);
    endtask

    typedef struct {
        logic        stall;
        logic        branch;
        logic [0:31] pc_in;
        logic        chk_pair;
        logic        req;
        logic [0:31] addr;
        logic        pv;
        logic [0:31] first;
        logic [0:31] second;
        logic [0:31] pc;
        logic        done;
    } vec_t;

    localparam int N_VEC = 11;
    vec_t vecs [N_VEC];

    initial begin
        logic saw_pv;
        int   n;

        // Straight-line program: four words, then an all-zero terminator at 0x10.
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h08, 1'b1, word_at(0), word_at(1), 32'h08, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h0, 32'h0, 32'h08, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h08, 1'b0, 32'h0, 32'h0, 32'h08, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, word_at(2), word_at(3), 32'h10, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 32'h10, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 32'h10, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, T_NOP_EVEN, T_NOP_ODD, 32'h10, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, T_NOP_EVEN, T_NOP_ODD, 32'h10, 1'b1};

        fill(4);
        lat = 1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_outs("reset", 1'b0, 32'h0, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            stall        = vecs[i].stall;
            branch_taken = vecs[i].branch;
            pc_input     = vecs[i].pc_in;
            check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pv,
                       vecs[i].chk_pair ? vecs[i].first  : first_inst,
                       vecs[i].chk_pair ? vecs[i].second : second_inst,
                       vecs[i].pc, vecs[i].done);
            @(negedge clock);
        end

        // Odd terminator: five valid words, zero at 0x14.
        fill(5);
        do_reset();
        wait_pair("oddterm p0");
        wait_pair("oddterm p1");
        wait_pair("oddterm p2");
        check_outs("oddterm last", 1'b0, 32'h10, 1'b1, word_at(4), T_NOP_ODD, 32'h14, 1'b0);
        @(negedge clock);
        check_outs("oddterm done", 1'b0, 32'h10, 1'b1, T_NOP_EVEN, T_NOP_ODD, 32'h14, 1'b1);
        repeat (3) @(negedge clock);
        check_outs("oddterm idle", 1'b0, 32'h10, 1'b1, T_NOP_EVEN, T_NOP_ODD, 32'h14, 1'b1);
        branch_taken = 1'b1;
        pc_input = 32'h0;
        @(negedge clock);
        branch_taken = 1'b0;
        check_outs("done redirect", 1'b1, 32'h0, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h0, 1'b0);

        // Stall hold for three cycles, then resume.
        fill(32);
        do_reset();
        wait_pair("stall p0");
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_outs($sformatf("stall%0d", k), 1'b0, 32'h08, 1'b1, word_at(0), word_at(1), 32'h08, 1'b0);
        end
        stall = 1'b0;
        @(negedge clock);
        check_outs("stall resume", 1'b1, 32'h08, 1'b0, word_at(0), word_at(1), 32'h08, 1'b0);

        // Odd branch target from HOLD, with stall also high: redirect wins.
        wait_pair("obr p1");
        stall = 1'b1;
        branch_taken = 1'b1;
        pc_input = 32'h27;
        @(negedge clock);
        check_outs("obr redirect", 1'b1, 32'h20, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h24, 1'b0);
        stall = 1'b0;
        branch_taken = 1'b0;
        wait_pair("obr pair");
        check_outs("obr result", 1'b0, 32'h28, 1'b1, T_NOP_EVEN, word_at(9), 32'h28, 1'b0);

        // Flush: redirect while the read to 0x0 is still outstanding.
        lat = 3;
        do_reset();
        wait_req("flush first");
        @(negedge clock);
        branch_taken = 1'b1;
        pc_input = 32'h40;
        @(negedge clock);
        branch_taken = 1'b0;
        check_outs("flush enter", 1'b0, 32'h40, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h40, 1'b0);
        saw_pv = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (pair_valid) saw_pv = 1'b1;
        end while (imem_if.imem_req !== 1'b1 && n < 30);
        check("flush req", 64'(imem_if.imem_req), 64'd1);
        check("flush addr", 64'(imem_if.imem_addr), 64'h40);
        check("flush stale dropped", 64'(saw_pv), 64'd0);
        wait_pair("flush pair");
        check_outs("flush result", 1'b0, 32'h48, 1'b1, word_at(16), word_at(17), 32'h48, 1'b0);

        // Reset in WAIT; the late response from before reset must be ignored.
        do_reset();
        wait_req("rst first");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_outs("rst midwait", 1'b0, 32'h0, 1'b0, T_NOP_EVEN, T_NOP_ODD, 32'h0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst late rvalid ignored", 64'(pair_valid), 64'd0);
        wait_pair("rst pair");
        check_outs("rst result", 1'b0, 32'h08, 1'b1, word_at(0), word_at(1), 32'h08, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
